multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 The port clk SHALL be an input, 1 bit wide, and act as the system clock; all state SHALL update on its rising edge.
REQ-003 The port reset_n SHALL be an input, 1 bit wide, and act as the asynchronous, active-low reset.
REQ-004 The port instr_opcode SHALL be an input, 4 bits wide, carrying bits [15:12] of the instruction on the fetch bus.
REQ-005 The port mem_ready SHALL be an input, 1 bit wide, and act as the memory handshake completion signal; it is sampled only while mem_read or mem_write is high.
REQ-006 The port zero SHALL be an input, 1 bit wide, carrying the ALU zero flag and valid in EXEC.
REQ-007 The port ALUOp SHALL be an output, 2 bits wide: 10 for load/store address add, 01 for branch compare, 00 for register-type operations decoded by Opcode.
REQ-008 The port Opcode SHALL be an output, 4 bits wide, carrying the latched opcode of the current instruction.
REQ-009 The outputs ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg and alu_src SHALL each be 1 bit wide and act as datapath strobes and selects.
REQ-010 The port pc_src SHALL be an output, 2 bits wide: 00 for PC+2, 01 for branch target, 10 for jump target.
REQ-011 The port state SHALL be an output, 3 bits wide, exposing the current FSM state for debug.
REQ-012 The port illegal SHALL be an output, 1 bit wide, acting as a sticky flag that indicates an undefined opcode was decoded.
REQ-013 The port retired SHALL be an output, 16 bits wide, counting completed instructions.

Function
REQ-014 The FSM states SHALL be encoded as IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100 and WB=101; codes 110 and 111 SHALL go to IDLE on the next edge.
REQ-015 The opcode classes SHALL be: LD=0000; ST=0001; R-type=0010–1001; BEQ=1011; BNE=1100; JMP=1101; illegal=1010, 1110, 1111.
REQ-016 IDLE SHALL hold all strobes at 0 and SHALL unconditionally move to FETCH after one cycle.
REQ-017 In FETCH, mem_read SHALL be 1; while mem_ready=0 the FSM SHALL stay in FETCH with every other strobe at 0.
REQ-018 In FETCH with mem_ready=1 in the same cycle, ir_write=1, pc_write=1 and pc_src=00; Opcode SHALL capture instr_opcode at that edge, and the next state SHALL be DECODE.
REQ-019 DECODE SHALL last exactly one cycle, and its exit SHALL depend on the opcode class:
- illegal: illegal set to 1, next state FETCH, instruction not retired;
- JMP: pc_write=1, pc_src=10, next state FETCH;
- all other classes: next state EXEC.
REQ-020 ALUOp SHALL be driven from the latched opcode class in EXEC, MEM and WB (LD/ST=10, BEQ/BNE=01, R-type=00), and SHALL be 00 in IDLE, FETCH and DECODE.
REQ-021 alu_src SHALL be 1 in EXEC, MEM and WB for LD/ST, and 0 otherwise.
REQ-022 EXEC SHALL last exactly one cycle, and its exit SHALL depend on the opcode class:
- BEQ: pc_write=zero;
- BNE: pc_write=~zero;
- both branches: pc_src=01, next state FETCH;
- LD/ST: next state MEM;
- R-type: next state WB.
REQ-023 In MEM, LD SHALL hold mem_read=1 and ST SHALL hold mem_write=1 until mem_ready=1; on that edge LD SHALL go to WB and ST SHALL go to FETCH.
REQ-024 WB SHALL last exactly one cycle with reg_write=1, mem_to_reg=1 for LD only, and next state FETCH.
REQ-025 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-026 retired SHALL increment by 1 on the edge that leaves DECODE for JMP, leaves EXEC for a branch, leaves MEM for ST, or leaves WB.
REQ-027 retired SHALL wrap from FFFF to 0000.
REQ-028 With zero-wait memory, instruction latency SHALL be: JMP 3, BEQ/BNE 4, ST 5, R-type 5, LD 6 cycles, counted from FETCH entry to the next FETCH entry.
REQ-029 Each memory wait cycle SHALL add exactly one cycle of latency.
REQ-030 Strobes SHALL be combinational from state, latched opcode, mem_ready and zero, and SHALL be glitch-free with respect to state.

Reset
REQ-031 When reset_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, Opcode=0000, illegal=0 and retired=0000, with all strobes, ALUOp and pc_src at 0.
REQ-032 A reset asserted mid-MEM SHALL drop mem_read and mem_write in the same cycle and SHALL abandon the transaction, with no retire.
REQ-033 After reset_n rises, the first FETCH SHALL begin on the second rising edge of clk.

Verification
REQ-034 The bench SHALL check an ADD: instr_opcode=0010 with mem_ready tied to 1 → states 001,010,011,101,001; ALUOp=00 in EXEC; reg_write=1 in WB only; retired=1.
REQ-035 The bench SHALL check an LD with 2 wait cycles in MEM: instr_opcode=0000 → ALUOp=10 and alu_src=1 from EXEC to WB; mem_read high for 3 MEM cycles; mem_to_reg=1 in WB; 8 cycles total.
REQ-036 The bench SHALL check BEQ and BNE each with zero=1 and then zero=0: BEQ gives pc_write=1,0 and BNE gives pc_write=0,1 in EXEC, with pc_src=01 and ALUOp=01.
REQ-037 The bench SHALL check an illegal opcode then a JMP: instr_opcode=1110 → illegal=1, retired unchanged, returns to FETCH; then 1101 → pc_src=10 in DECODE, retired+1, illegal still 1.
REQ-038 The bench SHALL check a reset mid-MEM: during an ST with mem_ready=0, pull reset_n low → mem_write=0 and state=000 immediately, retired=0.
REQ-039 The bench SHALL check counter wrap: preload retired to FFFF by running 65535 JMPs, then run one more JMP → retired=0000.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback and
// drives datapath strobes combinationally from state, latched opcode and handshakes.
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  instr_opcode,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Opcode,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_ST, C_R, C_BEQ, C_BNE, C_JMP, C_ILL
  } op_class_t;

  localparam logic [1:0] ALU_MEM = 2'b10;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b00;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    case (op)
      4'b0000:                   classify = C_LD;
      4'b0001:                   classify = C_ST;
      4'b1011:                   classify = C_BEQ;
      4'b1100:                   classify = C_BNE;
      4'b1101:                   classify = C_JMP;
      4'b1010, 4'b1110, 4'b1111: classify = C_ILL;
      default:                   classify = C_R;
    endcase
  endfunction

  function automatic logic [1:0] alu_op_of(input op_class_t c);
    case (c)
      C_LD, C_ST:   alu_op_of = ALU_MEM;
      C_BEQ, C_BNE: alu_op_of = ALU_BR;
      default:      alu_op_of = ALU_R;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q;
  logic              started_q;
  logic              retire_c;
  op_class_t         cls;
  logic              is_mem_op;

  always_comb cls = classify(opcode_q);
  always_comb is_mem_op = (cls == C_LD) || (cls == C_ST);

  // started_q holds IDLE one extra cycle after reset so the first FETCH lands on the second edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      started_q <= 1'b1;
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    illegal_d  = illegal_q;
    retire_c   = 1'b0;
    ALUOp      = ALU_R;
    pc_src     = PC_INC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (started_q) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          opcode_d = instr_opcode;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cls)
          C_ILL: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
          C_JMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        ALUOp   = alu_op_of(cls);
        alu_src = is_mem_op;
        case (cls)
          C_BEQ, C_BNE: begin
            pc_write = (cls == C_BEQ) ? zero : ~zero;
            pc_src   = PC_BR;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          C_LD, C_ST: state_d = S_MEM;
          C_R:        state_d = S_WB;
          default:    state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        ALUOp   = alu_op_of(cls);
        alu_src = is_mem_op;
        if (cls == C_LD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else if (cls == C_ST) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        ALUOp      = alu_op_of(cls);
        alu_src    = is_mem_op;
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LD);
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign state   = state_q;
  assign Opcode  = opcode_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: instruction classes,
// memory waits, branches, illegal/JMP, reset mid-MEM and retire counter wrap.
module tb_multicycle_control;

  logic        clk;
  logic        reset_n;
  logic [3:0]  instr_opcode;
  logic        mem_ready;
  logic        zero;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_opcode (instr_opcode),
    .mem_ready    (mem_ready),
    .zero         (zero),
    .ALUOp        (alu_op),
    .Opcode       (opcode),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src      (alu_src),
    .pc_src       (pc_src),
    .state        (state),
    .illegal      (illegal),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are examined 2 time units after the rising edge.
  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic run_branch(input string tag, input logic [3:0] op, input logic z,
                            input logic exp_pw, input logic [15:0] exp_ret);
    instr_opcode = op;
    mem_ready    = 1'b1;
    zero         = z;
    #1;
    check({tag, "_fetch"}, 16'(state), 16'h0001);
    step;
    check({tag, "_dec"}, 16'(state), 16'h0002);
    step;
    check({tag, "_exec"}, 16'(state), 16'h0003);
    check({tag, "_pw"}, 16'(pc_write), 16'(exp_pw));
    check({tag, "_pcsrc"}, 16'(pc_src), 16'h0001);
    check({tag, "_aluop"}, 16'(alu_op), 16'h0001);
    step;
    check({tag, "_back"}, 16'(state), 16'h0001);
    check({tag, "_ret"}, retired, exp_ret);
  endtask

  logic [2:0] ld_state [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
  logic       ld_rdy   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       ld_mr    [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       ld_as    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] ld_aop   [8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
  logic       ld_mtr   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset_n      = 1'b0;
    instr_opcode = 4'b0000;
    mem_ready    = 1'b0;
    zero         = 1'b0;
    #2;
    check("rst_state", 16'(state), 16'h0000);
    check("rst_opcode", 16'(opcode), 16'h0000);
    check("rst_illegal", 16'(illegal), 16'h0000);
    check("rst_retired", retired, 16'h0000);
    check("rst_strobes", 16'({ir_write, pc_write, reg_write, mem_read, mem_write,
                              mem_to_reg, alu_src, alu_op, pc_src}), 16'h0000);

    @(negedge clk);
    reset_n = 1'b1;
    step;
    check("rst_hold_idle", 16'(state), 16'h0000);
    step;
    check("first_fetch", 16'(state), 16'h0001);
    check("fetch_wait_mr", 16'(mem_read), 16'h0001);
    check("fetch_wait_strb", 16'({ir_write, pc_write, reg_write, mem_write}), 16'h0000);

    // ADD with zero-wait memory
    instr_opcode = 4'b0010;
    mem_ready    = 1'b1;
    #1;
    check("add_fetch_strb", 16'({ir_write, pc_write, pc_src}), 16'h000C);
    step;
    check("add_dec", 16'(state), 16'h0002);
    check("add_opcode", 16'(opcode), 16'h0002);
    check("add_dec_rw", 16'(reg_write), 16'h0000);
    step;
    check("add_exec", 16'(state), 16'h0003);
    check("add_exec_aluop", 16'(alu_op), 16'h0000);
    check("add_exec_rw", 16'(reg_write), 16'h0000);
    step;
    check("add_wb", 16'(state), 16'h0005);
    check("add_wb_rw", 16'(reg_write), 16'h0001);
    check("add_wb_mtr", 16'(mem_to_reg), 16'h0000);
    step;
    check("add_back", 16'(state), 16'h0001);
    check("add_ret", retired, 16'h0001);
    check("add_fetch_rw", 16'(reg_write), 16'h0000);

    // LD with two wait cycles in MEM: eight states FETCH..FETCH
    instr_opcode = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      mem_ready = ld_rdy[i];
      #1;
      check($sformatf("ld_state%0d", i), 16'(state), 16'(ld_state[i]));
      check($sformatf("ld_mr%0d", i), 16'(mem_read), 16'(ld_mr[i]));
      check($sformatf("ld_mw%0d", i), 16'(mem_write), 16'h0000);
      check($sformatf("ld_as%0d", i), 16'(alu_src), 16'(ld_as[i]));
      check($sformatf("ld_aop%0d", i), 16'(alu_op), 16'(ld_aop[i]));
      check($sformatf("ld_mtr%0d", i), 16'(mem_to_reg), 16'(ld_mtr[i]));
      if (i < 7) step;
    end
    check("ld_ret", retired, 16'h0002);

    run_branch("beq_z1", 4'b1011, 1'b1, 1'b1, 16'h0003);
    run_branch("beq_z0", 4'b1011, 1'b0, 1'b0, 16'h0004);
    run_branch("bne_z1", 4'b1100, 1'b1, 1'b0, 16'h0005);
    run_branch("bne_z0", 4'b1100, 1'b0, 1'b1, 16'h0006);

    // Illegal opcode followed by JMP
    instr_opcode = 4'b1110;
    mem_ready    = 1'b1;
    step;
    check("ill_dec", 16'(state), 16'h0002);
    check("ill_dec_pw", 16'(pc_write), 16'h0000);
    step;
    check("ill_back", 16'(state), 16'h0001);
    check("ill_flag", 16'(illegal), 16'h0001);
    check("ill_ret", retired, 16'h0006);
    instr_opcode = 4'b1101;
    step;
    check("jmp_dec", 16'(state), 16'h0002);
    check("jmp_pcsrc", 16'(pc_src), 16'h0002);
    check("jmp_pw", 16'(pc_write), 16'h0001);
    step;
    check("jmp_back", 16'(state), 16'h0001);
    check("jmp_ret", retired, 16'h0007);
    check("jmp_ill_sticky", 16'(illegal), 16'h0001);

    // Top of the R-type range goes through WB
    instr_opcode = 4'b1001;
    step;
    step;
    check("r9_exec", 16'(state), 16'h0003);
    step;
    check("r9_wb", 16'(state), 16'h0005);
    step;
    check("r9_ret", retired, 16'h0008);

    // ST stalled in MEM, then asynchronous reset
    instr_opcode = 4'b0001;
    step;
    step;
    check("st_exec_as", 16'(alu_src), 16'h0001);
    mem_ready = 1'b0;
    step;
    check("st_mem", 16'(state), 16'h0004);
    check("st_mem_mw", 16'({mem_read, mem_write}), 16'h0001);
    step;
    check("st_mem_hold", 16'(state), 16'h0004);
    reset_n = 1'b0;
    #1;
    check("st_rst_mw", 16'(mem_write), 16'h0000);
    check("st_rst_state", 16'(state), 16'h0000);
    check("st_rst_ret", retired, 16'h0000);
    check("st_rst_ill", 16'(illegal), 16'h0000);

    @(negedge clk);
    reset_n = 1'b1;
    step;
    step;
    check("rst2_fetch", 16'(state), 16'h0001);

    // Retire counter wrap: 65535 JMPs reach FFFF, one more wraps to 0
    instr_opcode = 4'b1101;
    mem_ready    = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      step;
      step;
    end
    check("wrap_pre", retired, 16'hFFFF);
    step;
    step;
    check("wrap_post", retired, 16'h0000);
    check("wrap_state", 16'(state), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected end of directed sequence");
    $fatal(1, "bench did not complete");
  end

endmodule
